// File: rtl/store_queue_unit.sv
// Circular store queue: in-order allocate, out-of-order resolve, in-order commit and drain.
// Optional store-to-load forwarding is built only when STORE_QUEUE_FWD_EN is defined.
module store_queue_unit #(
  parameter int unsigned SQ_SIZE = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CW      = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       id_sq_packet,
  output logic                       almost_full,
  input  logic [IDX_W+2*XLEN+4:0]    rs_sq_packet,
  input  logic [$clog2(CW+1)-1:0]    num_commit_insns,
  output logic [$clog2(CW+1)-1:0]    num_sent_insns,
  output logic [2*XLEN+4:0]          sq_dcache_packet,
  input  logic                       dcache_accept,
  output logic [IDX_W-1:0]           head,
  output logic [IDX_W-1:0]           tail,
  output logic                       tail_ready,
  input  logic [XLEN-1:0]            addr,
  input  logic [IDX_W-1:0]           tail_store,
  input  logic [3:0]                 load_byte_info,
  output logic [XLEN-1:0]            value,
  output logic [3:0]                 fwd_valid
);

  localparam int unsigned CntW = IDX_W + 1;
  localparam int unsigned SentW = $clog2(CW + 1);
  localparam logic [CntW-1:0] FullCount = CntW'(SQ_SIZE);
  localparam logic [CntW-1:0] AfCount = CntW'(SQ_SIZE - 1);

  logic [SQ_SIZE-1:0] ready_q;
  logic [XLEN-1:0]    addr_q [SQ_SIZE];
  logic [XLEN-1:0]    data_q [SQ_SIZE];
  logic [3:0]         mask_q [SQ_SIZE];
  logic [IDX_W-1:0]   head_q, tail_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [CntW-1:0]    ccount_q, ccount_d;

  logic               rs_valid;
  logic [IDX_W-1:0]   rs_idx;
  logic [XLEN-1:0]    rs_addr, rs_data;
  logic [3:0]         rs_mask;

  logic [SQ_SIZE-1:0] occ;
  logic [IDX_W-1:0]   off;
  logic               alloc, rs_ok, dc_valid, drain;

  assign rs_valid = rs_sq_packet[IDX_W+2*XLEN+4];
  assign rs_idx   = rs_sq_packet[IDX_W+2*XLEN+3 -: IDX_W];
  assign rs_addr  = rs_sq_packet[2*XLEN+3 -: XLEN];
  assign rs_data  = rs_sq_packet[XLEN+3 -: XLEN];
  assign rs_mask  = rs_sq_packet[3:0];

  // An entry is occupied when its distance from head is below the count.
  always_comb begin
    occ = '0;
    off = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      off    = IDX_W'(i) - head_q;
      occ[i] = {1'b0, off} < count_q;
    end
  end

  assign tail_ready  = &(ready_q | ~occ);
  assign almost_full = count_q >= AfCount;
  assign head        = head_q;
  assign tail        = tail_q;

  assign alloc    = id_sq_packet && (count_q != FullCount);
  assign rs_ok    = rs_valid && occ[rs_idx];
  assign dc_valid = (count_q != '0) && (ccount_q != '0) && ready_q[head_q];
  assign drain    = dc_valid && dcache_accept;

  assign sq_dcache_packet = {dc_valid, addr_q[head_q], data_q[head_q], mask_q[head_q]};
  assign num_sent_insns   = SentW'(drain);

  assign count_d  = count_q + CntW'(alloc) - CntW'(drain);
  assign ccount_d = ccount_q + CntW'(num_commit_insns) - CntW'(drain);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ccount_q <= '0;
      ready_q  <= '0;
      for (int i = 0; i < SQ_SIZE; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        ready_q[tail_q] <= 1'b0;
        addr_q[tail_q]  <= '0;
        data_q[tail_q]  <= '0;
        mask_q[tail_q]  <= '0;
        tail_q          <= tail_q + 1'b1;
      end
      if (rs_ok) begin
        ready_q[rs_idx] <= 1'b1;
        addr_q[rs_idx]  <= rs_addr;
        data_q[rs_idx]  <= rs_data;
        mask_q[rs_idx]  <= rs_mask;
      end
      // Drain clear comes last so it wins over a late execute write to head.
      if (drain) begin
        ready_q[head_q] <= 1'b0;
        addr_q[head_q]  <= '0;
        data_q[head_q]  <= '0;
        mask_q[head_q]  <= '0;
        head_q          <= head_q + 1'b1;
      end
      count_q  <= count_d;
      ccount_q <= ccount_d;
    end
  end

`ifdef STORE_QUEUE_FWD_EN
  logic [IDX_W-1:0] fwd_lim;
  logic [IDX_W-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest older match overwrites earlier ones.
  always_comb begin
    value     = '0;
    fwd_valid = '0;
    fwd_idx   = '0;
    fwd_lim   = tail_store - head_q - 1'b1;
    for (int k = 0; k < SQ_SIZE; k++) begin
      fwd_idx = head_q + IDX_W'(k);
      if ((CntW'(k) < count_q) && (IDX_W'(k) <= fwd_lim) && ready_q[fwd_idx] &&
          (addr_q[fwd_idx] == addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (load_byte_info[b] && mask_q[fwd_idx][b]) begin
            value[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
            fwd_valid[b]    = 1'b1;
          end
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{addr, tail_store, load_byte_info};
  assign value      = '0;
  assign fwd_valid  = '0;
`endif

endmodule

// File: tb/tb_store_queue_unit.sv
// Directed self-checking bench for store_queue_unit; forwarding expectations
// follow STORE_QUEUE_FWD_EN.
module tb_store_queue_unit;

  localparam int unsigned SQ_SIZE = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned CW      = 2;
`ifdef STORE_QUEUE_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    id_sq_packet;
  logic                    almost_full;
  logic [IDX_W+2*XLEN+4:0] rs_sq_packet;
  logic [1:0]              num_commit_insns;
  logic [1:0]              num_sent_insns;
  logic [2*XLEN+4:0]       sq_dcache_packet;
  logic                    dcache_accept;
  logic [IDX_W-1:0]        head, tail;
  logic                    tail_ready;
  logic [XLEN-1:0]         addr;
  logic [IDX_W-1:0]        tail_store;
  logic [3:0]              load_byte_info;
  logic [XLEN-1:0]         value;
  logic [3:0]              fwd_valid;

  int n_checks = 0;
  int n_errors = 0;

  store_queue_unit #(
    .SQ_SIZE(SQ_SIZE),
    .IDX_W  (IDX_W),
    .XLEN   (XLEN),
    .CW     (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .id_sq_packet    (id_sq_packet),
    .almost_full     (almost_full),
    .rs_sq_packet    (rs_sq_packet),
    .num_commit_insns(num_commit_insns),
    .num_sent_insns  (num_sent_insns),
    .sq_dcache_packet(sq_dcache_packet),
    .dcache_accept   (dcache_accept),
    .head            (head),
    .tail            (tail),
    .tail_ready      (tail_ready),
    .addr            (addr),
    .tail_store      (tail_store),
    .load_byte_info  (load_byte_info),
    .value           (value),
    .fwd_valid       (fwd_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic dispatch(input int n);
    for (int i = 0; i < n; i++) begin
      id_sq_packet = 1'b1;
      tick();
    end
    id_sq_packet = 1'b0;
  endtask

  task automatic execute(input logic [IDX_W-1:0] idx, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    rs_sq_packet = {1'b1, idx, a, d, m};
    tick();
    rs_sq_packet = '0;
  endtask

  task automatic commit(input int n);
    num_commit_insns = 2'(n);
    tick();
    num_commit_insns = '0;
  endtask

  task automatic drain(input int n);
    dcache_accept = 1'b1;
    for (int i = 0; i < n; i++) tick();
    dcache_accept = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [IDX_W-1:0] ts, input logic [3:0] bi);
    addr           = a;
    tail_store     = ts;
    load_byte_info = bi;
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    id_sq_packet     = 1'b0;
    rs_sq_packet     = '0;
    num_commit_insns = '0;
    dcache_accept    = 1'b0;
    addr             = '0;
    tail_store       = '0;
    load_byte_info   = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_head", head, 0);
    check("rst_tail", tail, 0);
    check("rst_af", almost_full, 0);
    check("rst_tready", tail_ready, 1);
    check("rst_dcvalid", sq_dcache_packet[2*XLEN+4], 0);
    check("rst_sent", num_sent_insns, 0);

    // Fill, wrap tail, ignore dispatch when full
    dispatch(7);
    check("fill7_tail", tail, 7);
    check("fill7_af", almost_full, 1);
    check("fill7_tready", tail_ready, 0);
    dispatch(1);
    check("fill8_tail", tail, 0);
    check("fill8_af", almost_full, 1);
    dispatch(1);
    check("full_ign_tail", tail, 0);
    check("full_head", head, 0);

    // Single store through to the dcache
    do_reset();
    dispatch(1);
    execute(0, 32'h100, 32'hDEADBEEF, 4'hF);
    check("pre_commit_valid", sq_dcache_packet[2*XLEN+4], 0);
    commit(1);
    check("dc_pkt", sq_dcache_packet, {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    check("stall_sent", num_sent_insns, 0);
    dcache_accept = 1'b1;
    #1;
    check("accept_sent", num_sent_insns, 1);
    tick();
    dcache_accept = 1'b0;
    check("drain_head", head, 1);
    check("drain_valid", sq_dcache_packet[2*XLEN+4], 0);
    check("drain_tready", tail_ready, 1);

    // Forwarding, youngest older store wins per byte
    do_reset();
    dispatch(2);
    execute(0, 32'h200, 32'h11223344, 4'hF);
    execute(1, 32'h200, 32'hAABBCCDD, 4'b0011);
    load(32'h200, 2, 4'hF);
    check("fwd_val_all", value, FwdEn ? 32'h1122CCDD : 32'h0);
    check("fwd_hit_all", fwd_valid, FwdEn ? 4'hF : 4'h0);
    load(32'h200, 1, 4'b1100);
    check("fwd_val_hi", value, FwdEn ? 32'h11220000 : 32'h0);
    check("fwd_hit_hi", fwd_valid, FwdEn ? 4'b1100 : 4'h0);
    load(32'h204, 2, 4'hF);
    check("fwd_miss_val", value, 0);
    check("fwd_miss_hit", fwd_valid, 0);

    // Fill, commit and drain all eight, then refill across the wrap
    do_reset();
    dispatch(8);
    for (int i = 0; i < 8; i++) execute(IDX_W'(i), 32'h400 + 32'(4 * i), 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) commit(2);
    drain(8);
    check("wrap_head", head, 0);
    check("wrap_tail", tail, 0);
    check("wrap_empty_valid", sq_dcache_packet[2*XLEN+4], 0);
    dispatch(3);
    check("refill_head", head, 0);
    check("refill_tail", tail, 3);
    dispatch(5);
    for (int i = 0; i < 5; i++) execute(IDX_W'(i), 32'h500, 32'h0, 4'hF);
    commit(2);
    commit(2);
    commit(1);
    drain(5);
    check("wrap5_head", head, 5);
    dispatch(3);
    check("wrap5_tail", tail, 3);
    execute(7, 32'h300, 32'h01020304, 4'hF);
    execute(1, 32'h300, 32'h0000AA00, 4'b0010);
    execute(2, 32'h300, 32'hFFFFFFFF, 4'hF);
    check("wrap5_tready", tail_ready, 0);
    load(32'h300, 2, 4'hF);
    check("wfwd_val", value, FwdEn ? 32'h0102AA04 : 32'h0);
    check("wfwd_hit", fwd_valid, FwdEn ? 4'hF : 4'h0);
    load(32'h300, 3, 4'hF);
    check("wfwd_young_val", value, FwdEn ? 32'hFFFFFFFF : 32'h0);

    // Asynchronous reset with committed stores waiting on a stalled dcache
    do_reset();
    dispatch(6);
    for (int i = 0; i < 5; i++) execute(IDX_W'(i), 32'h600 + 32'(4 * i), 32'h100 + 32'(i), 4'hF);
    commit(2);
    commit(2);
    commit(1);
    drain(1);
    check("pre_ar_head", head, 1);
    check("pre_ar_pkt", sq_dcache_packet, {1'b1, 32'h604, 32'h101, 4'hF});
    check("pre_ar_tready", tail_ready, 0);
    #3;
    reset = 1'b1;
    #1;
    check("ar_head", head, 0);
    check("ar_tail", tail, 0);
    check("ar_af", almost_full, 0);
    check("ar_tready", tail_ready, 1);
    check("ar_pkt", sq_dcache_packet, 0);
    check("ar_sent", num_sent_insns, 0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
